// File: rtl/atm_keypad_frontend.sv
// Keypad front end for the ATM core: builds account, PIN, menu option, amount and destination
// from key strobes and presents them on req/ack. Optional inactivity timeout: KEYPAD_TIMEOUT_EN.
module atm_keypad_frontend #(
    parameter int TIMEOUT_CYCLES = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        ack,
    output logic        req,
    output logic [11:0] accNumber,
    output logic [3:0]  pin,
    output logic [11:0] destinationAccNumber,
    output logic [2:0]  menuOption,
    output logic [10:0] amount,
    output logic        lang,
    output logic        key_err,
    output logic        session_end
);
    typedef enum logic [2:0] {S_ACC, S_PIN, S_MENU, S_AMT, S_DEST, S_REQ} state_t;

    localparam logic [3:0] K_ENTER  = 4'hA;
    localparam logic [3:0] K_CANCEL = 4'hB;
    localparam logic [3:0] K_LANG   = 4'hC;

    state_t      state_q;
    logic [2:0]  ndig_q;
    logic [11:0] acc_q;
    logic [11:0] dest_q;
    logic [3:0]  pin_q;
    logic [2:0]  menu_q;
    logic [10:0] amt_q;
    logic        lang_q;
    logic        req_q;
    logic        key_err_q;
    logic        session_end_q;

    logic [11:0] fld_val;
    logic [11:0] fld_lim;
    logic [2:0]  fld_maxd;
    logic [15:0] fld_d;
    logic        digit_ok;
    logic        is_digit;
    logic        timeout_hit;
    logic        cancel_d;

    // Candidate value of the active numeric field if the current key were appended.
    always_comb begin
        fld_val  = '0;
        fld_lim  = '0;
        fld_maxd = '0;
        case (state_q)
            S_ACC:  begin fld_val = acc_q;         fld_lim = 12'd4095; fld_maxd = 3'd4; end
            S_PIN:  begin fld_val = {8'd0, pin_q}; fld_lim = 12'd15;   fld_maxd = 3'd2; end
            S_AMT:  begin fld_val = {1'b0, amt_q}; fld_lim = 12'd2047; fld_maxd = 3'd4; end
            S_DEST: begin fld_val = dest_q;        fld_lim = 12'd4095; fld_maxd = 3'd4; end
            default: ;
        endcase
        fld_d    = 16'(fld_val) * 16'd10 + 16'(key_code);
        digit_ok = (ndig_q < fld_maxd) && (fld_d <= 16'(fld_lim));
    end

    assign is_digit = (key_code <= 4'd9);

`ifdef KEYPAD_TIMEOUT_EN
    localparam int IW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [IW-1:0] idle_q;
    logic          counting;

    assign counting    = (state_q != S_ACC) && (state_q != S_REQ);
    assign timeout_hit = counting && !key_valid && (idle_q == IW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
        end else if (!counting || key_valid || timeout_hit) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_q + IW'(1);
        end
    end
`else
    // No inactivity limit in this build; the parameter has no effect.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    assign cancel_d = (state_q != S_REQ) && ((key_valid && key_code == K_CANCEL) || timeout_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_ACC;
            ndig_q        <= '0;
            acc_q         <= '0;
            dest_q        <= '0;
            pin_q         <= '0;
            menu_q        <= '0;
            amt_q         <= '0;
            lang_q        <= 1'b0;
            req_q         <= 1'b0;
            key_err_q     <= 1'b0;
            session_end_q <= 1'b0;
        end else begin
            key_err_q     <= 1'b0;
            session_end_q <= 1'b0;
            if (state_q == S_REQ) begin
                if (ack) begin
                    req_q   <= 1'b0;
                    menu_q  <= '0;
                    amt_q   <= '0;
                    dest_q  <= '0;
                    state_q <= S_MENU;
                end
            end else if (cancel_d) begin
                state_q       <= S_ACC;
                ndig_q        <= '0;
                acc_q         <= '0;
                dest_q        <= '0;
                pin_q         <= '0;
                menu_q        <= '0;
                amt_q         <= '0;
                session_end_q <= 1'b1;
            end else if (key_valid) begin
                if (key_code == K_LANG) begin
                    lang_q <= ~lang_q;
                end else if (key_code == K_ENTER) begin
                    case (state_q)
                        S_MENU: begin
                            case (menu_q)
                                3'd3: begin
                                    state_q <= S_REQ;
                                    req_q   <= 1'b1;
                                    amt_q   <= '0;
                                end
                                3'd4, 3'd5, 3'd7: begin
                                    state_q <= S_AMT;
                                    amt_q   <= '0;
                                    ndig_q  <= '0;
                                end
                                3'd6: begin
                                    state_q <= S_DEST;
                                    dest_q  <= '0;
                                    ndig_q  <= '0;
                                end
                                default: key_err_q <= 1'b1;
                            endcase
                        end
                        default: begin
                            if (ndig_q == 3'd0) begin
                                key_err_q <= 1'b1;
                            end else begin
                                ndig_q <= '0;
                                case (state_q)
                                    S_ACC:  begin state_q <= S_PIN; pin_q <= '0; end
                                    S_PIN:  state_q <= S_MENU;
                                    S_DEST: begin state_q <= S_AMT; amt_q <= '0; end
                                    default: begin state_q <= S_REQ; req_q <= 1'b1; end
                                endcase
                            end
                        end
                    endcase
                end else if (is_digit) begin
                    if (state_q == S_MENU) begin
                        if (key_code >= 4'd3 && key_code <= 4'd7) begin
                            menu_q <= key_code[2:0];
                        end else begin
                            key_err_q <= 1'b1;
                        end
                    end else if (!digit_ok) begin
                        key_err_q <= 1'b1;
                    end else begin
                        ndig_q <= ndig_q + 3'd1;
                        case (state_q)
                            S_ACC:   acc_q  <= fld_d[11:0];
                            S_PIN:   pin_q  <= fld_d[3:0];
                            S_AMT:   amt_q  <= fld_d[10:0];
                            default: dest_q <= fld_d[11:0];
                        endcase
                    end
                end
            end
        end
    end

    assign req                  = req_q;
    assign accNumber            = acc_q;
    assign pin                  = pin_q;
    assign destinationAccNumber = dest_q;
    assign menuOption           = menu_q;
    assign amount               = amt_q;
    assign lang                 = lang_q;
    assign key_err              = key_err_q;
    assign session_end          = session_end_q;

endmodule
